// File: rtl/hood_pkg.sv
// Shared encodings for the range-hood mode controller: mode values, fan levels
// and the mode-to-fan mapping.
package hood_pkg;

  localparam logic [2:0] MODE_OFF       = 3'd0;
  localparam logic [2:0] MODE_STANDBY   = 3'd1;
  localparam logic [2:0] MODE_MENU      = 3'd2;
  localparam logic [2:0] MODE_LVL1      = 3'd3;
  localparam logic [2:0] MODE_LVL2      = 3'd4;
  localparam logic [2:0] MODE_LVL3      = 3'd5;
  localparam logic [2:0] MODE_EXIT_WAIT = 3'd6;
  localparam logic [2:0] MODE_CLEAN     = 3'd7;

  typedef enum logic [2:0] {
    ST_OFF       = MODE_OFF,
    ST_STANDBY   = MODE_STANDBY,
    ST_MENU      = MODE_MENU,
    ST_LVL1      = MODE_LVL1,
    ST_LVL2      = MODE_LVL2,
    ST_LVL3      = MODE_LVL3,
    ST_EXIT_WAIT = MODE_EXIT_WAIT,
    ST_CLEAN     = MODE_CLEAN
  } hood_state_e;

  localparam logic [1:0] FAN_OFF = 2'd0;
  localparam logic [1:0] FAN_L1  = 2'd1;
  localparam logic [1:0] FAN_L2  = 2'd2;
  localparam logic [1:0] FAN_L3  = 2'd3;

  function automatic logic [1:0] fan_for_state(input hood_state_e s);
    logic [1:0] f;
    case (s)
      ST_LVL1: f = FAN_L1;
      ST_LVL2: f = FAN_L2;
      ST_LVL3: f = FAN_L3;
      default: f = FAN_OFF;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/second_tick_gen.sv
// One-second strobe generator: a prescaler that wraps every TICKS_PER_SEC
// cycles and restarts from zero whenever clear is asserted.
module second_tick_gen #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  logic [PRESC_W-1:0] presc_r;

  // Prescaler: restart on clear, otherwise count and wrap at the last cycle of a second
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r <= PRESC_ZERO;
    end else if (clear) begin
      presc_r <= PRESC_ZERO;
    end else if (presc_r == PRESC_MAX) begin
      presc_r <= PRESC_ZERO;
    end else begin
      presc_r <= presc_r + PRESC_ONE;
    end
  end

  assign tick = (presc_r == PRESC_MAX);

endmodule

// File: rtl/hood_mode_control.sv
// Range-hood operating-mode FSM: menu navigation, fan levels, the timed
// hurricane level with its exit wait, and timed self-clean.
module hood_mode_control
  import hood_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned HURRICANE_SEC = 60,
  parameter int unsigned CLEAN_SEC     = 180,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             power_state,
  input  logic             menu_key,
  input  logic             lvl1_key,
  input  logic             lvl2_key,
  input  logic             lvl3_key,
  input  logic             clean_key,
  output logic [2:0]       mode,
  output logic [1:0]       fan_level,
  output logic [CNT_W-1:0] countdown,
  output logic             clean_done
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HURR  = CNT_W'(HURRICANE_SEC);
  localparam logic [CNT_W-1:0] CNT_CLEAN = CNT_W'(CLEAN_SEC);

  hood_state_e      state_r;
  hood_state_e      state_next_s;
  logic [CNT_W-1:0] countdown_r;
  logic [CNT_W-1:0] countdown_next_s;
  logic             hurricane_used_r;
  logic             hurricane_used_next_s;
  logic [1:0]       fan_level_r;
  logic             clean_done_r;
  logic             clean_done_next_s;
  logic             tick_s;
  logic             state_change_s;
  logic             tick_due_s;

  // The prescaler restarts on every mode change so a fresh timed mode gets a full first second
  assign state_change_s = (state_next_s != state_r);
  assign tick_due_s     = tick_s && (countdown_r != CNT_ZERO);

  second_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(state_change_s),
    .tick (tick_s)
  );

  // Next-state, countdown and hurricane-limit logic; power loss overrides every key
  always_comb begin
    state_next_s          = state_r;
    countdown_next_s      = countdown_r;
    hurricane_used_next_s = hurricane_used_r;
    clean_done_next_s     = 1'b0;
    if (!power_state) begin
      state_next_s          = ST_OFF;
      countdown_next_s      = CNT_ZERO;
      hurricane_used_next_s = 1'b0;
    end else begin
      case (state_r)
        ST_OFF: state_next_s = ST_STANDBY;
        ST_STANDBY: begin
          if (menu_key) state_next_s = ST_MENU;
          else          state_next_s = ST_STANDBY;
        end
        ST_MENU: begin
          // A spent hurricane request counts as no key, so lower-priority keys still act
          if (menu_key) begin
            state_next_s = ST_STANDBY;
          end else if (lvl3_key && !hurricane_used_r) begin
            state_next_s          = ST_LVL3;
            countdown_next_s      = CNT_HURR;
            hurricane_used_next_s = 1'b1;
          end else if (lvl2_key) begin
            state_next_s = ST_LVL2;
          end else if (lvl1_key) begin
            state_next_s = ST_LVL1;
          end else if (clean_key) begin
            state_next_s     = ST_CLEAN;
            countdown_next_s = CNT_CLEAN;
          end else begin
            state_next_s = ST_MENU;
          end
        end
        ST_LVL1: begin
          if (menu_key)      state_next_s = ST_STANDBY;
          else if (lvl2_key) state_next_s = ST_LVL2;
          else               state_next_s = ST_LVL1;
        end
        ST_LVL2: begin
          if (menu_key)      state_next_s = ST_STANDBY;
          else if (lvl1_key) state_next_s = ST_LVL1;
          else               state_next_s = ST_LVL2;
        end
        ST_LVL3: begin
          if (menu_key) begin
            state_next_s     = ST_EXIT_WAIT;
            countdown_next_s = CNT_HURR;
          end else if (tick_due_s) begin
            countdown_next_s = countdown_r - CNT_ONE;
            if (countdown_r == CNT_ONE) state_next_s = ST_LVL2;
            else                        state_next_s = ST_LVL3;
          end else begin
            state_next_s = ST_LVL3;
          end
        end
        ST_EXIT_WAIT: begin
          if (tick_due_s) begin
            countdown_next_s = countdown_r - CNT_ONE;
            if (countdown_r == CNT_ONE) state_next_s = ST_STANDBY;
            else                        state_next_s = ST_EXIT_WAIT;
          end else begin
            state_next_s = ST_EXIT_WAIT;
          end
        end
        ST_CLEAN: begin
          if (tick_due_s) begin
            countdown_next_s = countdown_r - CNT_ONE;
            if (countdown_r == CNT_ONE) begin
              state_next_s      = ST_STANDBY;
              clean_done_next_s = 1'b1;
            end else begin
              state_next_s = ST_CLEAN;
            end
          end else begin
            state_next_s = ST_CLEAN;
          end
        end
        default: begin
          state_next_s     = ST_OFF;
          countdown_next_s = CNT_ZERO;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= ST_OFF;
      countdown_r      <= CNT_ZERO;
      hurricane_used_r <= 1'b0;
      fan_level_r      <= FAN_OFF;
      clean_done_r     <= 1'b0;
    end else begin
      state_r          <= state_next_s;
      countdown_r      <= countdown_next_s;
      hurricane_used_r <= hurricane_used_next_s;
      fan_level_r      <= fan_for_state(state_next_s);
      clean_done_r     <= clean_done_next_s;
    end
  end

  assign mode       = state_r;
  assign fan_level  = fan_level_r;
  assign countdown  = countdown_r;
  assign clean_done = clean_done_r;

endmodule
